// File: rtl/sd_loader_pkg.sv
// sd_loader_pkg: shared types and helpers for the SD word loader.
//   state_t    - loader FSM encoding
//   idx_width  - width of the byte-lane index for a given word size
//   strb_mask  - byte-enable mask for a partially filled word
package sd_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // A 1-byte word still needs a 1-bit index so the packer logic is uniform.
  function automatic int idx_width(input int word_bytes);
    return (word_bytes > 1) ? $clog2(word_bytes) : 1;
  endfunction

  // Mask with one bit per filled lane. Lanes fill from bit 0 upward in
  // little-endian order and from the MS lane downward in big-endian order.
  function automatic logic [7:0] strb_mask(input int filled, input int word_bytes,
                                           input bit big_endian);
    logic [7:0] m;
    int         lane;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < filled && i < word_bytes) begin
        lane = big_endian ? (word_bytes - 1 - i) : i;
        m[lane[2:0]] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/sd_word_fifo.sv
// sd_word_fifo: synchronous word FIFO with a registered head.
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous flush to empty
//   push/push_data write request; ignored when full unless popping the same cycle
//   pop           consume the head (only effective while out_valid)
//   full, empty   occupancy flags (the displayed head counts as an entry)
//   out_valid/out_data registered head; appears the cycle after an entry lands
module sd_word_fifo #(
  parameter int DW    = 36,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CW-1:0] count, held;
  logic          do_pop, push_ok;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && out_valid;
  // A pop frees the slot the push lands in, so a full FIFO still accepts.
  assign push_ok   = push && (!full || do_pop);
  // Entries already stored before this edge, after the pop; a same-cycle
  // push is not visible at the head until the following cycle.
  assign held      = count - CW'(do_pop);
  assign rd_ptr_nx = rd_ptr + PW'(do_pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_ptr_nx;
      count     <= held + CW'(push_ok);
      out_valid <= (held != '0);
      if (held != '0) out_data <= mem[rd_ptr_nx];
    end
  end

endmodule

// File: rtl/sd_word_loader.sv
// sd_word_loader: packs the SD reader byte stream into words and writes
// them to memory through a small FIFO.
//   clk, rst            clock, asynchronous active-high reset
//   start               pulse; begins a load from IDLE or DONE
//   in_valid/in_byte    byte stream from the SD reader (cannot be stalled)
//   in_end              level; source has no more bytes
//   wr_valid/wr_ready   write handshake; wr_addr/wr_data/wr_strb the word
//   busy, done          load in progress / all words written (sticky)
//   overflow            sticky; a word was dropped on a full FIFO
//   bytes_loaded        bytes accepted in this load
module sd_word_loader
  import sd_loader_pkg::*;
#(
  parameter int                WORD_BYTES = 4,
  parameter int                FIFO_DEPTH = 8,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]       BIN_SIZE   = 32'h0010_0000,
  parameter bit                BIG_ENDIAN = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [7:0]              in_byte,
  input  logic                    in_end,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_data,
  output logic [WORD_BYTES-1:0]   wr_strb,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [31:0]             bytes_loaded
);

  localparam int              IW       = idx_width(WORD_BYTES);
  localparam int              DW       = 8 * WORD_BYTES;
  localparam logic [IW-1:0]   IDX_LAST = IW'(WORD_BYTES - 1);

  state_t                 state, state_nx;
  logic [IW-1:0]          idx, lane;
  logic [DW-1:0]          word_q, word_merged, push_data;
  logic [WORD_BYTES-1:0]  push_strb;
  logic [7:0]             part_mask;
  logic                   take_byte, word_full, push, clear, xfer;
  logic                   fifo_full, fifo_empty;
  logic [DW+WORD_BYTES-1:0] fifo_out;

  assign xfer = wr_valid && wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    take_byte = 1'b0;
    clear     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx = ST_LOAD;
          clear    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (bytes_loaded >= BIN_SIZE) begin
          state_nx = ST_FLUSH;
        end else if (in_valid) begin
          take_byte = 1'b1;
          if ({1'b0, bytes_loaded} + 33'd1 >= {1'b0, BIN_SIZE}) state_nx = ST_FLUSH;
        end else if (in_end) begin
          state_nx = ST_FLUSH;
        end
      end
      ST_FLUSH: state_nx = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !wr_valid) state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Merge the arriving byte into its lane; a completed word is pushed
  // straight from this merged value so it lands in the same cycle.
  assign lane = BIG_ENDIAN ? (IDX_LAST - idx) : idx;

  always_comb begin
    word_merged = word_q;
    word_merged[lane*8 +: 8] = in_byte;
  end

  assign word_full = take_byte && (idx == IDX_LAST);
  assign push      = word_full || ((state == ST_FLUSH) && (idx != '0));
  assign push_data = word_full ? word_merged : word_q;
  assign part_mask = strb_mask(int'(idx), WORD_BYTES, BIG_ENDIAN);
  assign push_strb = word_full ? '1 : part_mask[WORD_BYTES-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      word_q       <= '0;
      bytes_loaded <= '0;
      overflow     <= 1'b0;
      wr_addr      <= BASE_ADDR;
    end else if (clear) begin
      idx          <= '0;
      word_q       <= '0;
      bytes_loaded <= '0;
      overflow     <= 1'b0;
      wr_addr      <= BASE_ADDR;
    end else begin
      if (take_byte) begin
        bytes_loaded <= bytes_loaded + 32'd1;
        if (word_full) begin
          idx    <= '0;
          word_q <= '0;   // unfilled lanes of a later partial word read zero
        end else begin
          idx    <= idx + 1'b1;
          word_q <= word_merged;
        end
      end
      if (push && fifo_full && !xfer) overflow <= 1'b1;
      if (xfer) wr_addr <= wr_addr + ADDR_W'(WORD_BYTES);
    end
  end

  sd_word_fifo #(
    .DW    (DW + WORD_BYTES),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data ({push_strb, push_data}),
    .pop       (xfer),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .out_valid (wr_valid),
    .out_data  (fifo_out)
  );

  assign wr_data = fifo_out[DW-1:0];
  assign wr_strb = fifo_out[DW +: WORD_BYTES];
  assign done    = (state == ST_DONE);
  assign busy    = (state == ST_LOAD) || (state == ST_FLUSH) || (state == ST_DRAIN);

endmodule

// File: tb/tb_sd_word_loader.sv
module tb_sd_word_loader;

  localparam int          ND           = 3;
  localparam int          P_DEPTH [ND] = '{2, 8, 8};
  localparam logic [31:0] P_BIN   [ND] = '{32'd100, 32'd8, 32'd6};
  localparam bit          P_BIG   [ND] = '{1'b0, 1'b1, 1'b0};

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_end, wr_ready;
  logic [7:0]    in_byte;
  logic [ND-1:0] wr_valid, busy, done, overflow;
  logic [31:0]   wr_addr      [ND];
  logic [31:0]   wr_data      [ND];
  logic [3:0]    wr_strb      [ND];
  logic [31:0]   bytes_loaded [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    sd_word_loader #(
      .WORD_BYTES (4),
      .FIFO_DEPTH (P_DEPTH[g]),
      .ADDR_W     (32),
      .BASE_ADDR  (32'h0),
      .BIN_SIZE   (P_BIN[g]),
      .BIG_ENDIAN (P_BIG[g])
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_byte      (in_byte),
      .in_end       (in_end),
      .wr_valid     (wr_valid[g]),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr[g]),
      .wr_data      (wr_data[g]),
      .wr_strb      (wr_strb[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .overflow     (overflow[g]),
      .bytes_loaded (bytes_loaded[g])
    );
  end

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  stim [16];
  // writes seen on each port
  int          got_n    [ND];
  logic [31:0] got_addr [ND][8];
  logic [31:0] got_data [ND][8];
  logic [3:0]  got_strb [ND][8];
  // reference expectations
  int          exp_n     [ND];
  bit          exp_ovf   [ND];
  int          exp_bytes [ND];
  logic [31:0] exp_addr  [ND][8];
  logic [31:0] exp_data  [ND][8];
  logic [3:0]  exp_strb  [ND][8];
  // stall tracking
  bit          stalled   [ND];
  logic [31:0] hold_addr [ND];
  logic [31:0] hold_data [ND];
  logic [3:0]  hold_strb [ND];
  logic [ND-1:0] obs_valid;

  // Reference: the accepted bytes are the first min(n, BIN_SIZE); they are
  // cut into 4-byte words in order, the last one possibly partial. When the
  // port is stalled for the whole load only the first FIFO_DEPTH words fit.
  task automatic model(input int k, input int n, input bit stall);
    int acc, nw, lane;
    acc = (n < int'(P_BIN[k])) ? n : int'(P_BIN[k]);
    nw  = (acc + 3) / 4;
    exp_ovf[k]   = stall && (nw > P_DEPTH[k]);
    exp_n[k]     = exp_ovf[k] ? P_DEPTH[k] : nw;
    exp_bytes[k] = acc;
    for (int w = 0; w < exp_n[k]; w++) begin
      exp_addr[k][w] = 32'(w * 4);
      exp_data[k][w] = '0;
      exp_strb[k][w] = '0;
      for (int j = 0; j < 4; j++) begin
        if (w * 4 + j < acc) begin
          lane = P_BIG[k] ? 3 - j : j;
          exp_data[k][w][lane*8 +: 8] = stim[w * 4 + j];
          exp_strb[k][w][lane] = 1'b1;
        end
      end
    end
  endtask

  function automatic bit rdy_sel(input int mode, input bit late, inout int lows);
    if (mode == 0) return 1'b1;
    if (mode == 2) begin
      // never more than two stalled cycles in a row
      if (lows >= 2 || $urandom_range(0, 2) != 0) begin
        lows = 0;
        return 1'b1;
      end
      lows++;
      return 1'b0;
    end
    return late;
  endfunction

  // One clock: observe outputs at the falling edge, apply new inputs, and
  // log any write that the coming rising edge will transfer.
  task automatic cycle(input bit v, input logic [7:0] b, input bit e,
                       input bit s, input bit rdy);
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      obs_valid[k] = wr_valid[k];
      if (stalled[k]) begin
        vectors++;
        if (wr_valid[k] !== 1'b1 || wr_addr[k] !== hold_addr[k] ||
            wr_data[k] !== hold_data[k] || wr_strb[k] !== hold_strb[k]) begin
          errors++;
          $display("FAIL stall_hold dut%0d: got v=%b a=%h d=%h s=%h, want v=1 a=%h d=%h s=%h",
                   k, wr_valid[k], wr_addr[k], wr_data[k], wr_strb[k],
                   hold_addr[k], hold_data[k], hold_strb[k]);
        end
      end
    end
    in_valid = v; in_byte = b; in_end = e; start = s; wr_ready = rdy;
    for (int k = 0; k < ND; k++) begin
      if (wr_valid[k] && rdy) begin
        if (got_n[k] < 8) begin
          got_addr[k][got_n[k]] = wr_addr[k];
          got_data[k][got_n[k]] = wr_data[k];
          got_strb[k][got_n[k]] = wr_strb[k];
        end
        got_n[k]++;
      end
      stalled[k]   = wr_valid[k] && !rdy;
      hold_addr[k] = wr_addr[k];
      hold_data[k] = wr_data[k];
      hold_strb[k] = wr_strb[k];
    end
  endtask

  task automatic begin_load();
    for (int k = 0; k < ND; k++) got_n[k] = 0;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  // mode 0: ready high; 1: stalled through the load; 2: random ready;
  // 3: stalled until the last byte, then ready
  task automatic feed(input int n, input int mode, input bit gaps, inout int lows);
    int fed;
    fed = 0;
    while (fed < n) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        cycle(1'b0, 8'h00, 1'b0, 1'b0, rdy_sel(mode, 1'b0, lows));
      end else begin
        cycle(1'b1, stim[fed], 1'b0, 1'b0,
              rdy_sel(mode, (mode == 3) && (fed == n - 1), lows));
        fed++;
      end
    end
  endtask

  task automatic finish_load(input int n, input int mode, input int lows_in);
    int  guard, lows;
    bit  all;
    lows  = lows_in;
    guard = 0;
    all   = 1'b0;
    while (!all && guard < 300) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, rdy_sel(mode, !(mode == 1 && guard < 6), lows));
      guard++;
      all = (done === {ND{1'b1}});
    end
    vectors++;
    if (!all) begin
      errors++;
      $display("FAIL load_timeout: done=%b, want %b", done, {ND{1'b1}});
    end
    for (int k = 0; k < ND; k++) begin
      model(k, n, mode == 1);
      vectors++;
      if (got_n[k] !== exp_n[k]) begin
        errors++;
        $display("FAIL write_count dut%0d: got %0d, want %0d", k, got_n[k], exp_n[k]);
      end
      for (int i = 0; i < exp_n[k] && i < got_n[k] && i < 8; i++) begin
        vectors++;
        if (got_addr[k][i] !== exp_addr[k][i] || got_data[k][i] !== exp_data[k][i] ||
            got_strb[k][i] !== exp_strb[k][i]) begin
          errors++;
          $display("FAIL write dut%0d #%0d: got a=%h d=%h s=%h, want a=%h d=%h s=%h",
                   k, i, got_addr[k][i], got_data[k][i], got_strb[k][i],
                   exp_addr[k][i], exp_data[k][i], exp_strb[k][i]);
        end
      end
      vectors++;
      if (bytes_loaded[k] !== 32'(exp_bytes[k])) begin
        errors++;
        $display("FAIL bytes_loaded dut%0d: got %0d, want %0d", k, bytes_loaded[k], exp_bytes[k]);
      end
      vectors++;
      if (overflow[k] !== exp_ovf[k]) begin
        errors++;
        $display("FAIL overflow dut%0d: got %b, want %b", k, overflow[k], exp_ovf[k]);
      end
      vectors++;
      if ({done[k], busy[k], wr_valid[k]} !== 3'b100) begin
        errors++;
        $display("FAIL end_flags dut%0d: got done/busy/valid=%b%b%b, want 100",
                 k, done[k], busy[k], wr_valid[k]);
      end
      vectors++;
      if (wr_addr[k] !== 32'(exp_n[k] * 4)) begin
        errors++;
        $display("FAIL end_addr dut%0d: got %h, want %h", k, wr_addr[k], 32'(exp_n[k] * 4));
      end
    end
  endtask

  task automatic run_load(input int n, input int mode, input bit gaps);
    int lows;
    lows = 0;
    begin_load();
    feed(n, mode, gaps, lows);
    finish_load(n, mode, lows);
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < ND; k++) begin
      vectors++;
      if (wr_valid[k] !== 1'b0 || wr_addr[k] !== 32'h0 || wr_data[k] !== 32'h0 ||
          wr_strb[k] !== 4'h0 || busy[k] !== 1'b0 || done[k] !== 1'b0 ||
          overflow[k] !== 1'b0 || bytes_loaded[k] !== 32'h0) begin
        errors++;
        $display("FAIL %s dut%0d: got v=%b a=%h d=%h s=%h busy=%b done=%b ovf=%b bytes=%0d, want all zero",
                 tag, k, wr_valid[k], wr_addr[k], wr_data[k], wr_strb[k],
                 busy[k], done[k], overflow[k], bytes_loaded[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_end = 1'b0; wr_ready = 1'b0;
    for (int k = 0; k < ND; k++) stalled[k] = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < ND; k++) begin
      vectors++;
      if (bytes_loaded[k] !== 32'h0 || busy[k] !== 1'b0 || got_n[k] !== 0) begin
        errors++;
        $display("FAIL idle_ignore dut%0d: got bytes=%0d busy=%b writes=%0d, want 0 0 0",
                 k, bytes_loaded[k], busy[k], got_n[k]);
      end
    end
  endtask

  task automatic test_nominal();
    int lows;
    lows = 0;
    for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
    begin_load();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, stim[i], 1'b0, 1'b0, 1'b1);
      // fourth byte sampled at the edge after i==3: head still empty one
      // cycle later, valid the cycle after that
      if (i == 4 || i == 5) begin
        vectors++;
        if (obs_valid !== ((i == 4) ? 3'b000 : 3'b111)) begin
          errors++;
          $display("FAIL first_word_latency step%0d: got wr_valid=%b, want %b",
                   i - 3, obs_valid, (i == 4) ? 3'b000 : 3'b111);
        end
      end
    end
    finish_load(8, 0, lows);
  endtask

  task automatic test_partial();
    for (int i = 0; i < 6; i++) stim[i] = 8'hAA + 8'(i);
    run_load(6, 0, 1'b0);
    run_load(5, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 12; i++) stim[i] = 8'($urandom);
    run_load(12, 1, 1'b0);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 12; i++) stim[i] = 8'($urandom);
    run_load(12, 3, 1'b0);
  endtask

  task automatic test_random();
    int n, mode;
    for (int it = 0; it < 8; it++) begin
      n    = $urandom_range(1, 14);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
      run_load(n, mode, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_restart();
    int lows;
    lows = 0;
    for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
    begin_load();
    feed(3, 0, 1'b0, lows);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("reset_midload");
    for (int k = 0; k < ND; k++) stalled[k] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
    run_load(4, 0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < ND; k++) got_n[k] = 0;
    test_reset();
    test_idle_ignore();
    test_nominal();
    test_partial();
    test_backpressure();
    test_partial();
    test_full_push_pop();
    test_random();
    test_backpressure();
    test_reset_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
